uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares the single debug UART transmitter among several snapshot requesters (register-file dump, pipeline latch dumps, data-memory word, step reports). Each requester presents a wide packed snapshot plus a byte length; the scheduler grants one at a time round-robin, captures the snapshot, and streams it byte by byte to `uart_tx`, pacing on `tx_done`. It sits between the debugger command FSM and `uart_tx`, and replaces per-state byte loops with one sequenced, arbitrated path.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- MAX_BYTES, 128: max snapshot length in bytes (128 bytes covers the 32x32 register file).
- LEN_W, $clog2(MAX_BYTES+1): length field width.
- HEADER_EN, 1: when 1, each frame is preceded by a tag byte.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  NUM_REQ  request per requester; level, held until accepted.
- i_req_data  in  NUM_REQ*MAX_BYTES*8  packed snapshots; requester k occupies slice [k*MAX_BYTES*8 +: MAX_BYTES*8].
- i_req_len  in  NUM_REQ*LEN_W  byte count per requester, slice [k*LEN_W +: LEN_W].
- o_req_ready  out  NUM_REQ  one-hot acceptance; high only for the granted requester while IDLE.
- o_req_done  out  NUM_REQ  one-cycle pulse when that requester's frame has fully transmitted.
- o_tx_start  out  1  one-cycle start pulse to `uart_tx`.
- o_tx_data  out  8  byte to transmit; stable from the start pulse until `i_tx_done`.
- i_tx_done  in  1  one-cycle pulse from `uart_tx` at end of stop bit.
- o_busy  out  1  high from acceptance until the done pulse.
- o_grant_id  out  3  index of the current or last granted requester.

## Operation
- States: IDLE, START, WAIT_DONE, FINISH.
- IDLE: if any valid bit is set, grant the first valid index at or after `rr_ptr` (cyclic search). `o_req_ready[g]` is high combinationally in that cycle. On handshake (valid & ready):
  - capture the slice of `i_req_data` into the shift buffer;
  - set `remaining` = min(len, MAX_BYTES);
  - set `hdr_pending` = HEADER_EN;
  - go to START.
- START: assert `o_tx_start` for exactly one cycle, then go to WAIT_DONE. The byte sent is:
  - 8'hA0 | g if `hdr_pending`;
  - otherwise buffer[7:0].
  - If there is nothing to send (HEADER_EN=0 and `remaining`=0), do not pulse; go straight to FINISH.
- WAIT_DONE: on `i_tx_done`:
  - if a header was sent, clear `hdr_pending`;
  - otherwise shift the buffer right by 8 bits and decrement `remaining`.
  - Then go to START if bytes are left, else FINISH.
- FINISH: pulse `o_req_done[g]` for one cycle, set `rr_ptr` = (g+1) mod NUM_REQ, return to IDLE.
- Bytes go out least significant first. Bits beyond `len*8` are never sent.
- A len greater than MAX_BYTES is clamped to MAX_BYTES.
- `i_tx_done` outside WAIT_DONE is ignored.
- Changes on `i_req_data` or `i_req_valid` after acceptance do not affect the frame in flight.
- A requester that keeps valid high after its done pulse is re-arbitrated normally. Round-robin guarantees any waiting requester is served within NUM_REQ frames.

## Timing
- Reset values:
  - o_req_ready = 0, o_req_done = 0;
  - o_tx_start = 0, o_tx_data = 8'h00;
  - o_busy = 0, o_grant_id = 0;
  - rr_ptr = 0, state = IDLE.
- Reset mid-frame aborts immediately with no done pulse. `uart_tx` completes or is reset on its own.
- Acceptance occurs in cycle T. The first `o_tx_start` pulse is at T+1.
- Each `i_tx_done` at cycle D produces the next start pulse at D+2 (WAIT_DONE to START, then the pulse).
- The last `i_tx_done` at D produces the done pulse at D+1, and IDLE at D+2. The earliest next acceptance is D+2.
- o_busy is high T+1 .. done-pulse cycle inclusive.
- Frame byte count on the wire = HEADER_EN + min(len, MAX_BYTES).

## Test plan
- Single request: req1, len=4, data=32'hDEADBEEF, HEADER_EN=1 -> bytes A1, EF, BE, AD, DE; one `o_req_done[1]` pulse one cycle after the 5th `tx_done`.
- Contention: valid=4'b1111 held, each len=1 -> grant order 0,1,2,3,0. Tags A0..A3 then A0; no starvation.
- Zero length: HEADER_EN=0, len=0 -> no `o_tx_start` pulse; `o_req_done` two cycles after acceptance.
- Clamp: len=200 with MAX_BYTES=128 -> exactly 129 start pulses (header + 128).
- Spurious/late `tx_done`: a `tx_done` pulse in IDLE -> no state change. Data change after acceptance -> the originally captured bytes are sent.
- Reset mid-frame: assert `i_reset` after the 2nd byte -> all outputs at reset values next edge; no done pulse; a new request after release starts from a fresh header.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one debug UART transmitter among NUM_REQ snapshot requesters.
//   A round-robin arbiter grants one requester while idle, its packed
//   snapshot is captured into a shift buffer, and the frame (optional tag
//   byte 8'hA0|grant, then min(len, MAX_BYTES) bytes, LSB byte first) is
//   streamed to uart_tx one byte per start/done handshake.
//
// Ports
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_req_valid      per-requester request level, held until accepted
//   i_req_data       packed snapshots, requester k at [k*MAX_BYTES*8 +: MAX_BYTES*8]
//   i_req_len        byte counts, requester k at [k*LEN_W +: LEN_W]
//   o_req_ready      one-hot grant, only while idle
//   o_req_done       one-cycle pulse when a requester's frame has finished
//   o_tx_start       one-cycle start pulse to uart_tx
//   o_tx_data        byte for uart_tx, stable from start pulse until i_tx_done
//   i_tx_done        end-of-byte pulse from uart_tx
//   o_busy           high from the cycle after acceptance through the done pulse
//   o_grant_id       current or last granted requester
module uart_tx_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BYTES = 128,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1),
  parameter int HEADER_EN = 1
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*MAX_BYTES*8-1:0] i_req_data,
  input  logic [NUM_REQ*LEN_W-1:0]       i_req_len,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [NUM_REQ-1:0]             o_req_done,
  output logic                           o_tx_start,
  output logic [7:0]                     o_tx_data,
  input  logic                           i_tx_done,
  output logic                           o_busy,
  output logic [2:0]                     o_grant_id
);

  localparam int BUF_W = MAX_BYTES * 8;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_BYTES);
  localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             hdr_q, hdr_d;
  logic             adv_q, adv_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       rr_q, rr_d;

  // Round-robin search: first valid index at or after rr_q, wrapping.
  logic [7:0] valid_pad;
  logic       arb_found;
  logic [2:0] arb_idx;
  logic [3:0] cand;

  assign valid_pad = 8'(i_req_valid);

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + 4'(i);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (!arb_found && valid_pad[cand[2:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[2:0];
      end
    end
  end

  logic [BUF_W-1:0] req_slice;
  logic [LEN_W-1:0] req_len_raw;
  logic [LEN_W-1:0] req_len_clamped;

  assign req_slice       = i_req_data[int'(arb_idx) * BUF_W +: BUF_W];
  assign req_len_raw     = i_req_len[int'(arb_idx) * LEN_W +: LEN_W];
  assign req_len_clamped = (req_len_raw > LEN_MAX) ? LEN_MAX : req_len_raw;

  // Ready is forced low while reset is asserted so the reset view of the
  // outputs is clean even if requesters hold valid.
  always_comb begin
    o_req_ready = '0;
    if (state_q == S_IDLE && arb_found && !i_reset) begin
      o_req_ready = ONE_HOT0 << arb_idx;
    end
  end

  logic       more_bytes;
  logic [3:0] grant_inc;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    rem_d      = rem_q;
    hdr_d      = hdr_q;
    adv_d      = adv_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    o_tx_start = 1'b0;
    o_req_done = '0;
    more_bytes = 1'b0;
    grant_inc  = {1'b0, grant_q} + 4'd1;

    unique case (state_q)
      S_IDLE: begin
        // Ready is asserted for arb_idx whenever a valid exists, so a found
        // candidate is the handshake.
        if (arb_found) begin
          grant_d = arb_idx;
          buf_d   = req_slice;
          rem_d   = req_len_clamped;
          hdr_d   = (HEADER_EN != 0);
          adv_d   = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (hdr_q || rem_q != '0) begin
          o_tx_start = 1'b1;
          state_d    = S_WAIT_DONE;
        end else begin
          state_d = S_FINISH;
        end
      end

      S_WAIT_DONE: begin
        // A non-final byte completion spends one extra cycle here (adv_q)
        // so the next start pulse lands two cycles after tx_done, while the
        // final completion goes straight to FINISH one cycle after tx_done.
        if (adv_q) begin
          adv_d   = 1'b0;
          state_d = S_START;
        end else if (i_tx_done) begin
          if (hdr_q) begin
            hdr_d      = 1'b0;
            more_bytes = (rem_q != '0);
          end else begin
            buf_d      = buf_q >> 8;
            rem_d      = rem_q - LEN_ONE;
            more_bytes = (rem_q > LEN_ONE);
          end
          if (more_bytes) begin
            adv_d = 1'b1;
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        o_req_done = ONE_HOT0 << grant_q;
        rr_d       = (grant_inc >= 4'(NUM_REQ)) ? 3'd0 : grant_inc[2:0];
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      rem_q   <= '0;
      hdr_q   <= 1'b0;
      adv_q   <= 1'b0;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      hdr_q   <= hdr_d;
      adv_q   <= adv_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign o_tx_data  = hdr_q ? (8'hA0 | {5'b0, grant_q}) : buf_q[7:0];
  assign o_busy     = (state_q != S_IDLE);
  assign o_grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: a main instance (4 requesters, 128-byte
// snapshots, tag byte enabled) served by a randomly-delayed uart_tx
// responder, and a small instance without tag bytes for zero-length frames.
module tb_uart_tx_scheduler;
  localparam int NREQ  = 4;
  localparam int MAXB  = 128;
  localparam int LW    = $clog2(MAXB + 1);
  localparam int SW    = MAXB * 8;
  localparam int NREQ0 = 2;
  localparam int MAXB0 = 8;
  localparam int LW0   = $clog2(MAXB0 + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*SW-1:0] req_data  = '0;
  logic [NREQ*LW-1:0] req_len   = '0;
  logic [NREQ-1:0]    req_ready, req_done;
  logic               tx_start, busy;
  logic [7:0]         tx_data;
  logic [2:0]         grant_id;
  logic               tx_done;
  logic               resp_done = 1'b0;
  logic               spur_done = 1'b0;

  logic [NREQ0-1:0]         req_valid0 = '0;
  logic [NREQ0*MAXB0*8-1:0] req_data0  = '0;
  logic [NREQ0*LW0-1:0]     req_len0   = '0;
  logic [NREQ0-1:0]         req_ready0, req_done0;
  logic                     tx_start0, busy0;
  logic [7:0]               tx_data0;
  logic [2:0]               grant_id0;
  logic                     tx_done0 = 1'b0;

  assign tx_done = resp_done | spur_done;

  uart_tx_scheduler #(.NUM_REQ(NREQ), .MAX_BYTES(MAXB), .LEN_W(LW), .HEADER_EN(1)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_len(req_len),
    .o_req_ready(req_ready), .o_req_done(req_done),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .i_tx_done(tx_done),
    .o_busy(busy), .o_grant_id(grant_id)
  );

  uart_tx_scheduler #(.NUM_REQ(NREQ0), .MAX_BYTES(MAXB0), .LEN_W(LW0), .HEADER_EN(0)) dut0 (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid0), .i_req_data(req_data0), .i_req_len(req_len0),
    .o_req_ready(req_ready0), .o_req_done(req_done0),
    .o_tx_start(tx_start0), .o_tx_data(tx_data0), .i_tx_done(tx_done0),
    .o_busy(busy0), .o_grant_id(grant_id0)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  byte unsigned got_q[$];
  byte unsigned exp_q[$];
  int unsigned  start_cyc_q[$];
  int unsigned  txdone_cyc_q[$];
  int unsigned  done_cyc_q[$];
  int           done_id_q[$];
  int unsigned  busy_cnt, stable_viol, ready_viol;
  logic         in_flight = 1'b0;
  logic [7:0]   flight_byte;
  int           resp_max = 3;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_start) begin
          got_q.push_back(tx_data);
          start_cyc_q.push_back(cyc);
          in_flight   = 1'b1;
          flight_byte = tx_data;
        end else if (in_flight && tx_data !== flight_byte) begin
          stable_viol++;
        end
        if (tx_done) begin
          txdone_cyc_q.push_back(cyc);
          in_flight = 1'b0;
        end
        for (int k = 0; k < NREQ; k++) begin
          if (req_done[k]) begin
            done_id_q.push_back(k);
            done_cyc_q.push_back(cyc);
          end
        end
        if ($countones(req_ready) > 1 || (busy && req_ready != '0)) ready_viol++;
        if (busy) busy_cnt++;
      end else begin
        in_flight = 1'b0;
      end
    end
  end

  initial begin : responder
    int d;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        d = int'($urandom_range(1, resp_max));
        repeat (d) @(posedge clk);
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [SW-1:0] rand_vec();
    logic [SW-1:0] v;
    for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference frame: tag byte, then min(len, MAXB) bytes, least significant first.
  function automatic void add_expected(int id, logic [SW-1:0] d, int len);
    int n;
    n = (len > MAXB) ? MAXB : len;
    exp_q.push_back(8'hA0 | 8'(id));
    for (int i = 0; i < n; i++) exp_q.push_back(d[i*8 +: 8]);
  endfunction

  task automatic clear_logs();
    got_q.delete(); exp_q.delete(); start_cyc_q.delete(); txdone_cyc_q.delete();
    done_cyc_q.delete(); done_id_q.delete();
    busy_cnt = 0; stable_viol = 0; ready_viol = 0;
  endtask

  task automatic do_reset(int n);
    @(posedge clk); #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(int k, logic [SW-1:0] d, int len);
    req_data[k*SW +: SW] = d;
    req_len[k*LW +: LW]  = LW'(len);
  endtask

  task automatic accept(int k, output int unsigned t, output bit ok);
    ok = 0; t = 0;
    @(posedge clk); #1 req_valid[k] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready[k]) begin ok = 1; t = cyc; break; end
    end
    @(posedge clk); #1 req_valid[k] = 1'b0;
  endtask

  task automatic wait_done_count(int n, int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_id_q.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    req_data  = {NREQ{rand_vec()}};
    @(negedge clk);
    total++; if (req_ready !== '0)    begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    total++; if (req_done !== '0)     begin bad++; $display("FAIL reset_done got=%b exp=0", req_done); end
    total++; if (tx_start !== 1'b0)   begin bad++; $display("FAIL reset_start got=%b exp=0", tx_start); end
    total++; if (tx_data !== 8'h00)   begin bad++; $display("FAIL reset_txdata got=%h exp=00", tx_data); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (grant_id !== 3'd0)   begin bad++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    logic [SW-1:0] d;
    logic [7:0] want [5] = '{8'hA1, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int unsigned t;
    bit ok;
    clear_logs();
    d = rand_vec();
    d[31:0] = 32'hDEADBEEF;
    set_req(1, d, 4);
    accept(1, t, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_accept got=timeout exp=ready[1]"); end
    wait_done_count(1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done got=timeout exp=done pulse"); end
    total++; if (got_q.size() != 5) begin bad++; $display("FAIL single_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== want[i]) begin bad++; $display("FAIL single_byte[%0d] got=%02h exp=%02h", i, got_q[i], want[i]); end
    end
    if (ok && start_cyc_q.size() == 5 && txdone_cyc_q.size() == 5) begin
      total++; if (done_id_q[0] != 1) begin bad++; $display("FAIL single_done_id got=%0d exp=1", done_id_q[0]); end
      total++; if (start_cyc_q[0] != t + 1) begin bad++; $display("FAIL single_first_start got=%0d exp=%0d", start_cyc_q[0], t + 1); end
      for (int i = 1; i < 5; i++) begin
        total++;
        if (start_cyc_q[i] != txdone_cyc_q[i-1] + 2) begin
          bad++; $display("FAIL single_start_gap[%0d] got=%0d exp=%0d", i, start_cyc_q[i], txdone_cyc_q[i-1] + 2);
        end
      end
      total++; if (done_cyc_q[0] != txdone_cyc_q[4] + 1) begin bad++; $display("FAIL single_done_time got=%0d exp=%0d", done_cyc_q[0], txdone_cyc_q[4] + 1); end
      total++; if (busy_cnt != done_cyc_q[0] - t) begin bad++; $display("FAIL single_busy_cycles got=%0d exp=%0d", busy_cnt, done_cyc_q[0] - t); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || grant_id !== 3'd1) begin bad++; $display("FAIL single_idle got=busy%b/grant%0d exp=busy0/grant1", busy, grant_id); end
  endtask

  task automatic test_contention();
    logic [SW-1:0] d [NREQ];
    int order [5] = '{0, 1, 2, 3, 0};
    bit ok;
    do_reset(2);
    clear_logs();
    for (int k = 0; k < NREQ; k++) begin d[k] = rand_vec(); set_req(k, d[k], 1); end
    for (int i = 0; i < 5; i++) add_expected(order[i], d[order[i]], 1);
    @(posedge clk); #1 req_valid = '1;
    wait_done_count(5, 300, ok);
    @(posedge clk); #1 req_valid = '0;
    total++; if (!ok) begin bad++; $display("FAIL contention_done got=%0d frames exp=5", done_id_q.size()); end
    for (int i = 0; i < 5 && i < done_id_q.size(); i++) begin
      total++; if (done_id_q[i] != order[i]) begin bad++; $display("FAIL contention_order[%0d] got=%0d exp=%0d", i, done_id_q[i], order[i]); end
    end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL contention_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL contention_byte[%0d] got=%02h exp=%02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_zero_len();
    int unsigned t, dcyc;
    bit ok, got_done;
    int starts;
    logic [NREQ0-1:0] dval;
    logic busy_seen;
    req_data0 = {$urandom, $urandom, $urandom, $urandom};
    req_len0[0 +: LW0]   = LW0'(5);
    req_len0[LW0 +: LW0] = '0;
    @(posedge clk); #1 req_valid0 = 2'b10;
    ok = 0; t = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready0[1]) begin ok = 1; t = cyc; break; end
    end
    @(posedge clk); #1 req_valid0 = '0;
    total++; if (!ok) begin bad++; $display("FAIL zero_accept got=timeout exp=ready[1]"); end
    starts = 0; got_done = 0; dcyc = 0; dval = '0; busy_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (tx_start0) starts++;
      if (cyc == t + 1) busy_seen = busy0;
      if (req_done0 != '0 && !got_done) begin got_done = 1; dcyc = cyc; dval = req_done0; end
    end
    total++; if (starts != 0) begin bad++; $display("FAIL zero_starts got=%0d exp=0", starts); end
    total++; if (!got_done || dcyc != t + 2) begin bad++; $display("FAIL zero_done_time got=%0d exp=%0d", dcyc, t + 2); end
    total++; if (dval !== 2'b10) begin bad++; $display("FAIL zero_done_id got=%b exp=10", dval); end
    total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL zero_busy got=%b exp=1", busy_seen); end
  endtask

  task automatic test_clamp();
    logic [SW-1:0] d;
    int unsigned t;
    bit ok;
    clear_logs();
    resp_max = 1;
    d = rand_vec();
    set_req(2, d, 200);
    add_expected(2, d, 200);
    accept(2, t, ok);
    total++; if (!ok) begin bad++; $display("FAIL clamp_accept got=timeout exp=ready[2]"); end
    wait_done_count(1, 1500, ok);
    total++; if (!ok) begin bad++; $display("FAIL clamp_done got=timeout exp=done pulse"); end
    total++; if (got_q.size() != 129) begin bad++; $display("FAIL clamp_count got=%0d exp=129", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL clamp_byte[%0d] got=%02h exp=%02h", i, got_q[i], exp_q[i]); end
    end
    resp_max = 3;
  endtask

  task automatic test_spurious_and_change();
    logic [SW-1:0] d;
    int unsigned t;
    bit ok;
    int starts;
    clear_logs();
    @(posedge clk); #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0;
    starts = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (tx_start || busy) starts++;
    end
    total++; if (starts != 0) begin bad++; $display("FAIL spurious_idle got=%0d active cycles exp=0", starts); end
    clear_logs();
    d = rand_vec();
    set_req(0, d, 3);
    add_expected(0, d, 3);
    accept(0, t, ok);
    total++; if (!ok) begin bad++; $display("FAIL change_accept got=timeout exp=ready[0]"); end
    set_req(0, rand_vec(), 9);
    wait_done_count(1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL change_done got=timeout exp=done pulse"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL change_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL change_byte[%0d] got=%02h exp=%02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [SW-1:0] d;
    int unsigned t;
    bit ok;
    clear_logs();
    set_req(3, rand_vec(), 6);
    accept(3, t, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_accept got=timeout exp=ready[3]"); end
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (txdone_cyc_q.size() >= 2) begin ok = 1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL midrst_second_byte got=timeout exp=2 tx_done"); end
    @(posedge clk); #1 rst = 1'b1; req_valid = 4'b0001;
    @(negedge clk);
    total++;
    if (req_ready !== '0 || req_done !== '0 || tx_start !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || grant_id !== 3'd0) begin
      bad++;
      $display("FAIL midrst_outputs got=ready%b done%b start%b data%02h busy%b grant%0d exp=all zero",
               req_ready, req_done, tx_start, tx_data, busy, grant_id);
    end
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    total++; if (done_id_q.size() != 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", done_id_q.size()); end
    clear_logs();
    d = rand_vec();
    set_req(3, d, 2);
    add_expected(3, d, 2);
    accept(3, t, ok);
    wait_done_count(1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_new_done got=timeout exp=done pulse"); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_new_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_new_byte[%0d] got=%02h exp=%02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // Model: every masked requester raises valid together and drops it once
  // accepted; grants follow a cyclic scan from the pointer, which moves to
  // one past each served requester.
  task automatic test_random();
    int model_rr;
    int order_q[$];
    logic [NREQ-1:0] mask, pending, acc;
    logic [SW-1:0] d [NREQ];
    int len [NREQ];
    int g, n;
    bit ok;
    do_reset(2);
    model_rr = 0;
    for (int r = 0; r < 8; r++) begin
      clear_logs();
      order_q.delete();
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int k = 0; k < NREQ; k++) begin
        d[k]   = rand_vec();
        len[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 12));
        set_req(k, d[k], len[k]);
      end
      pending = mask;
      while (pending != '0) begin
        g = -1;
        for (int i = 0; i < NREQ; i++) begin
          if (g < 0 && pending[(model_rr + i) % NREQ]) g = (model_rr + i) % NREQ;
        end
        order_q.push_back(g);
        add_expected(g, d[g], len[g]);
        pending[g] = 1'b0;
        model_rr = (g + 1) % NREQ;
      end
      n = $countones(mask);
      @(posedge clk); #1 req_valid = mask;
      ok = 0;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        acc = req_valid & req_ready;
        if (done_id_q.size() >= n) begin ok = 1; break; end
        @(posedge clk); #1;
        req_valid = req_valid & ~acc;
      end
      req_valid = '0;
      total++; if (!ok) begin bad++; $display("FAIL rand%0d_done got=%0d frames exp=%0d", r, done_id_q.size(), n); end
      for (int i = 0; i < order_q.size() && i < done_id_q.size(); i++) begin
        total++; if (done_id_q[i] != order_q[i]) begin bad++; $display("FAIL rand%0d_order[%0d] got=%0d exp=%0d", r, i, done_id_q[i], order_q[i]); end
      end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_byte[%0d] got=%02h exp=%02h", r, i, got_q[i], exp_q[i]); end
      end
      total++; if (stable_viol != 0) begin bad++; $display("FAIL rand%0d_txdata_stable got=%0d changes exp=0", r, stable_viol); end
      total++; if (ready_viol != 0) begin bad++; $display("FAIL rand%0d_ready_onehot got=%0d bad cycles exp=0", r, ready_viol); end
      repeat (6) @(posedge clk);
    end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_contention();
    test_zero_len();
    test_clamp();
    test_spurious_and_change();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
